// File: rtl/iir_channel_scheduler.sv
// Time-multiplexed first-order Q1.15 IIR shared by NCH channels, round-robin sample arbitration.
// Optional: define IIR_SCHED_SAT_EN to saturate results; default wraps to 16 bits.
module iir_channel_scheduler #(
  parameter int          NCH     = 4,
  parameter logic [15:0] B0_INIT = 16'h1000,
  parameter logic [15:0] B1_INIT = 16'h0CCC,
  parameter logic [15:0] A1_INIT = 16'h0CCC,
  localparam int         CHW     = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    in_valid,
  input  logic [16*NCH-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [CHW-1:0]    out_ch,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT} state_t;

  state_t              r_state;
  logic [CHW-1:0]      r_ptr;
  logic [CHW-1:0]      r_ch;
  logic signed [15:0]  r_x;
  logic signed [34:0]  r_acc;
  logic signed [15:0]  r_x1 [NCH];
  logic signed [15:0]  r_y1 [NCH];
  logic [15:0]         r_b0_s, r_b1_s, r_a1_s;
  logic signed [15:0]  r_b0_a, r_b1_a, r_a1_a;
  logic                r_out_valid;
  logic [15:0]         r_out_data;
  logic [CHW-1:0]      r_out_ch;
  logic                r_busy;

  logic                w_any;
  logic [CHW-1:0]      w_gch;
  logic [15:0]         w_gx;
  logic signed [15:0]  w_coef;
  logic signed [15:0]  w_samp;
  logic signed [31:0]  w_prod;
  logic signed [34:0]  w_acc_next;
  logic signed [19:0]  w_sh;
  logic [15:0]         w_y;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign busy      = r_busy;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int unsigned v_idx;
    w_any = 1'b0;
    w_gch = '0;
    v_idx = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      v_idx = (int'(r_ptr) + i) % NCH;
      if (!w_any && in_valid[v_idx[CHW-1:0]]) begin
        w_any = 1'b1;
        w_gch = v_idx[CHW-1:0];
      end
    end
  end

  assign w_gx = in_data[{w_gch, 4'b0000} +: 16];

  always_comb begin
    in_ready = '0;
    if (r_state == IDLE && !RESET && w_any)
      in_ready = NCH'(1) << w_gch;
  end

  // One shared multiplier; the state selects which coefficient/sample pair feeds it.
  always_comb begin
    w_coef = r_b0_a;
    w_samp = r_x;
    case (r_state)
      MAC1: begin
        w_coef = r_b1_a;
        w_samp = r_x1[r_ch];
      end
      MAC2: begin
        w_coef = r_a1_a;
        w_samp = r_y1[r_ch];
      end
      default: ;
    endcase
  end

  assign w_prod = 32'(w_coef) * 32'(w_samp);

  always_comb begin
    w_acc_next = r_acc;
    case (r_state)
      MAC0:    w_acc_next = 35'(w_prod);
      MAC1:    w_acc_next = r_acc + 35'(w_prod);
      MAC2:    w_acc_next = r_acc - 35'(w_prod);
      default: ;
    endcase
  end

  assign w_sh = w_acc_next[34:15];

  always_comb begin
`ifdef IIR_SCHED_SAT_EN
    if (w_sh > 20'sd32767)
      w_y = 16'h7FFF;
    else if (w_sh < -20'sd32768)
      w_y = 16'h8000;
    else
      w_y = w_sh[15:0];
`else
    w_y = w_sh[15:0];
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_ptr       <= CHW'(NCH - 1);
      r_ch        <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_b0_s      <= B0_INIT;
      r_b1_s      <= B1_INIT;
      r_a1_s      <= A1_INIT;
      r_b0_a      <= B0_INIT;
      r_b1_a      <= B1_INIT;
      r_a1_a      <= A1_INIT;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_busy      <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        r_x1[k] <= '0;
        r_y1[k] <= '0;
      end
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    r_b0_s <= cfg_wdata;
          2'd1:    r_b1_s <= cfg_wdata;
          2'd2:    r_a1_s <= cfg_wdata;
          default: ;
        endcase
      end
      // Active set only follows the shadow while idle, so a sample never mixes old and new.
      if (r_state == IDLE) begin
        r_b0_a <= r_b0_s;
        r_b1_a <= r_b1_s;
        r_a1_a <= r_a1_s;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_x     <= w_gx;
            r_ch    <= w_gch;
            r_ptr   <= w_gch;
            r_busy  <= 1'b1;
            r_state <= MAC0;
          end
        end
        MAC0: begin
          r_acc   <= w_acc_next;
          r_state <= MAC1;
        end
        MAC1: begin
          r_acc   <= w_acc_next;
          r_state <= MAC2;
        end
        MAC2: begin
          r_acc       <= w_acc_next;
          r_out_data  <= w_y;
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          r_x1[r_ch]  <= r_x;
          r_y1[r_ch]  <= w_y;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Randomized self-checking bench for iir_channel_scheduler against an arithmetic reference model.
module tb_iir_channel_scheduler;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NCH-1:0]    in_valid;
  logic [16*NCH-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [CHW-1:0]    out_ch;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [15:0]       cfg_wdata;
  logic              busy;
  logic [15:0]       tb_x [NCH];

  int checks;
  int errors;

  int m_x1 [NCH];
  int m_y1 [NCH];
  int m_b0, m_b1, m_a1;
  int m_ptr;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int k = 0; k < NCH; k++) in_data[16*k +: 16] = tb_x[k];
  end

  iir_channel_scheduler #(.NCH(NCH)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy)
  );

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_x1[k] = 0;
      m_y1[k] = 0;
    end
    m_b0  = sx(16'h1000);
    m_b1  = sx(16'h0CCC);
    m_a1  = sx(16'h0CCC);
    m_ptr = NCH - 1;
  endfunction

  function automatic void model_cfg(input logic [1:0] a, input logic [15:0] d);
    if (a == 2'd0) m_b0 = sx(d);
    else if (a == 2'd1) m_b1 = sx(d);
    else if (a == 2'd2) m_a1 = sx(d);
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] vm);
    for (int i = 1; i <= NCH; i++) begin
      if (vm[(m_ptr + i) % NCH]) begin
        m_ptr = (m_ptr + i) % NCH;
        return m_ptr;
      end
    end
    return -1;
  endfunction

  // y = floor((b0*x + b1*x1 - a1*y1) / 2^15), then wrapped or clamped to 16 bits.
  function automatic logic [15:0] model_sample(input int ch, input logic [15:0] x);
    longint acc, q;
    logic [15:0] y;
    acc = longint'(m_b0) * longint'(sx(x)) + longint'(m_b1) * longint'(m_x1[ch])
        - longint'(m_a1) * longint'(m_y1[ch]);
    q = acc >>> 15;
`ifdef IIR_SCHED_SAT_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    y = q[15:0];
    m_x1[ch] = sx(x);
    m_y1[ch] = sx(y);
    return y;
  endfunction

  // Drives one request from IDLE and reports what the DUT did; callers compare.
  task automatic serve(input logic [NCH-1:0] vm, input logic we, input logic [1:0] wa,
                       input logic [15:0] wd, output logic [NCH-1:0] g, output logic [15:0] d,
                       output logic [CHW-1:0] c, output int lat, output bit to);
    int n;
    to = 1'b0; g = '0; d = '0; c = '0; lat = 0;
    out_ready = 1'b1;
    in_valid = vm; cfg_we = we; cfg_addr = wa; cfg_wdata = wd;
    #1;
    n = 0;
    while (in_ready == '0 && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    if (in_ready == '0) begin
      to = 1'b1; in_valid = '0; cfg_we = 1'b0;
      return;
    end
    g = in_ready;
    @(negedge CLK);
    in_valid = '0; cfg_we = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge CLK); lat++;
    end
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    d = out_data; c = out_ch;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = '1; out_ready = 1'b1; cfg_we = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge CLK);
    in_valid = '0; RESET = 1'b0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_impulse();
    logic [NCH-1:0] g; logic [15:0] d, ey; logic [CHW-1:0] c; int lat, eg; bit to;
    tb_x[0] = 16'h1000;
    eg = model_grant(4'b0001); ey = model_sample(eg, tb_x[0]);
    serve(4'b0001, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
    checks++; if (to) begin errors++; $display("FAIL impulse_timeout: got timeout want response"); end
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL impulse_grant: got %b want 0001", g); end
    checks++; if (d !== 16'h0200) begin errors++; $display("FAIL impulse_y0: got %h want 0200", d); end
    checks++; if (c !== 2'd0) begin errors++; $display("FAIL impulse_ch: got %0d want 0", c); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL impulse_latency: got %0d want 4", lat); end
    tb_x[0] = 16'h0000;
    eg = model_grant(4'b0001); ey = model_sample(eg, tb_x[0]);
    serve(4'b0001, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
    checks++; if (d !== 16'h0166) begin errors++; $display("FAIL impulse_y1: got %h want 0166", d); end
    checks++; if (d !== ey) begin errors++; $display("FAIL impulse_model: got %h want %h", d, ey); end
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] g; logic [15:0] d, ey; logic [CHW-1:0] c, prev; int lat, eg; bit to, hit2;
    hit2 = 1'b0; prev = CHW'(m_ptr);
    for (int r = 0; r < 8; r++) begin
      eg = model_grant('1);
      for (int k = 0; k < NCH; k++) tb_x[k] = 16'h0;
      if (eg == 2 && !hit2) tb_x[2] = 16'h1000;
      ey = model_sample(eg, tb_x[eg]);
      serve('1, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
      checks++; if (to) begin errors++; $display("FAIL rr_timeout: round %0d got timeout", r); end
      checks++; if (g !== (4'b0001 << eg)) begin errors++; $display("FAIL rr_grant: round %0d got %b want ch %0d", r, g, eg); end
      checks++; if (c !== CHW'(prev + 2'd1)) begin errors++; $display("FAIL rr_order: round %0d got ch %0d want %0d", r, c, CHW'(prev + 2'd1)); end
      checks++; if (d !== ey) begin errors++; $display("FAIL rr_data: round %0d got %h want %h", r, d, ey); end
      if (eg == 2 && !hit2) begin
        hit2 = 1'b1;
        checks++; if (d !== 16'h0200) begin errors++; $display("FAIL rr_ch2_impulse: got %h want 0200", d); end
      end
      prev = c;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ey; int eg, n;
    tb_x[1] = 16'($urandom);
    eg = model_grant(4'b0010); ey = model_sample(eg, tb_x[1]);
    out_ready = 1'b0; in_valid = 4'b0010;
    #1;
    n = 0;
    while (in_ready == '0 && n < 20) begin @(negedge CLK); #1; n++; end
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", in_ready); end
    @(negedge CLK);
    in_valid = '1;
    n = 0;
    while (!out_valid && n < 12) begin @(negedge CLK); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_data !== ey) begin errors++; $display("FAIL bp_data: cycle %0d got %h want %h", i, out_data, ey); end
      checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL bp_ch: cycle %0d got %0d want 1", i, out_ch); end
      checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b want 0000", i, in_ready); end
      checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: cycle %0d got busy %b valid %b want 1 1", i, busy, out_valid); end
      @(negedge CLK); #1;
    end
    in_valid = '0; out_ready = 1'b1;
    @(negedge CLK); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %b busy %b want 0 0", out_valid, busy); end
    @(negedge CLK); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 4'b0) begin errors++; $display("FAIL bp_single: got valid %b ready %b want 0 0000", out_valid, in_ready); end
  endtask

  task automatic test_coeff();
    logic [NCH-1:0] g; logic [15:0] d, ey; logic [CHW-1:0] c; int lat, eg, n; bit to;
    tb_x[0] = 16'h0;
    eg = model_grant(4'b0001); ey = model_sample(eg, tb_x[0]);
    out_ready = 1'b1; in_valid = 4'b0001;
    #1;
    n = 0;
    while (in_ready == '0 && n < 20) begin @(negedge CLK); #1; n++; end
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL cfg_grant: got %b want 0001", in_ready); end
    @(negedge CLK); in_valid = '0;
    @(negedge CLK); cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h7FFF;
    @(negedge CLK); cfg_addr = 2'd1;
    @(negedge CLK); cfg_addr = 2'd2; cfg_wdata = 16'h0000;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== ey) begin errors++; $display("FAIL cfg_old_coef: got valid %b data %h want 1 %h", out_valid, out_data, ey); end
    @(negedge CLK); cfg_we = 1'b0;
    model_cfg(2'd0, 16'h7FFF); model_cfg(2'd1, 16'h7FFF); model_cfg(2'd2, 16'h0000);
    @(negedge CLK);
    tb_x[0] = 16'h7FFF;
    eg = model_grant(4'b0001); ey = model_sample(eg, tb_x[0]);
    serve(4'b0001, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
    checks++; if (d !== 16'h7FFE) begin errors++; $display("FAIL cfg_full_1: got %h want 7FFE", d); end
    eg = model_grant(4'b0001); ey = model_sample(eg, tb_x[0]);
    serve(4'b0001, 1'b1, 2'd0, 16'h1000, g, d, c, lat, to);
`ifdef IIR_SCHED_SAT_EN
    checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL cfg_full_2: got %h want 7FFF", d); end
`else
    checks++; if (d !== 16'hFFFC) begin errors++; $display("FAIL cfg_full_2: got %h want FFFC", d); end
`endif
    model_cfg(2'd0, 16'h1000);
    tb_x[0] = 16'h1000;
    eg = model_grant(4'b0001); ey = model_sample(eg, tb_x[0]);
    serve(4'b0001, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
    checks++; if (to || d !== ey) begin errors++; $display("FAIL cfg_next_grant: got %h want %h", d, ey); end
  endtask

  task automatic test_reset_midop();
    logic [NCH-1:0] g; logic [15:0] d; logic [CHW-1:0] c; int lat, n; bit to;
    tb_x[0] = 16'h4000; out_ready = 1'b1; in_valid = 4'b0001;
    #1;
    n = 0;
    while (in_ready == '0 && n < 20) begin @(negedge CLK); #1; n++; end
    @(negedge CLK); in_valid = '0;
    @(negedge CLK); RESET = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_state: got valid %b busy %b want 0 0", out_valid, busy); end
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    for (int k = 0; k < NCH; k++) tb_x[k] = 16'h0;
    tb_x[0] = 16'h1000;
    void'(model_grant('1)); void'(model_sample(0, tb_x[0]));
    serve('1, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
    checks++; if (g !== 4'b0001 || c !== 2'd0) begin errors++; $display("FAIL midreset_ptr: got grant %b ch %0d want 0001 0", g, c); end
    checks++; if (d !== 16'h0200) begin errors++; $display("FAIL midreset_y0: got %h want 0200", d); end
    tb_x[0] = 16'h0;
    void'(model_grant(4'b0001)); void'(model_sample(0, tb_x[0]));
    serve(4'b0001, 1'b0, 2'd0, 16'h0, g, d, c, lat, to);
    checks++; if (d !== 16'h0166) begin errors++; $display("FAIL midreset_y1: got %h want 0166", d); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] g, vm; logic [15:0] d, ey, wd; logic [CHW-1:0] c; logic [1:0] wa;
    logic we; int lat, eg; bit to;
    for (int it = 0; it < 40; it++) begin
      vm = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int k = 0; k < NCH; k++) tb_x[k] = 16'($urandom);
      we = ($urandom_range(0, 3) == 0);
      wa = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      eg = model_grant(vm);
      ey = model_sample(eg, tb_x[eg]);
      serve(vm, we, wa, wd, g, d, c, lat, to);
      if (we) model_cfg(wa, wd);
      checks++; if (to) begin errors++; $display("FAIL rand_timeout: iter %0d", it); end
      checks++; if (g !== (4'b0001 << eg)) begin errors++; $display("FAIL rand_grant: iter %0d got %b want ch %0d", it, g, eg); end
      checks++; if (c !== CHW'(eg)) begin errors++; $display("FAIL rand_ch: iter %0d got %0d want %0d", it, c, eg); end
      checks++; if (d !== ey) begin errors++; $display("FAIL rand_data: iter %0d got %h want %h", it, d, ey); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL rand_latency: iter %0d got %0d want 4", it, lat); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    in_valid = '0; out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
    for (int k = 0; k < NCH; k++) tb_x[k] = 16'h0;
    model_reset();
    test_reset();
    test_impulse();
    test_round_robin();
    test_backpressure();
    test_coeff();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
